calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter ENTER_SW, default 4, operand width in bits.
REQ-002 Parameter ALU_SW, default 4, operation-code width.
REQ-003 Parameter RECORD, default 2, number of key inputs.
REQ-004 Parameter LED, default 3, number of status LEDs.
REQ-005 Parameter DEB_CYCLES, default 16, debounce stability count in clocks (>=2).
REQ-006 Parameter TIMEOUT, default 255, maximum clocks to wait for alu_done (>=1).
REQ-007 Ports: one clock; reset is asynchronous and active-low:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_number  in  ENTER_SW  operand switches, already polarity-corrected.
- arif  in  ALU_SW  operation select.
- key  in  RECORD  raw buttons, active-low; key[1] = record, key[0] = execute.
- alu_done  in  1  ALU result-valid pulse.
- alu_err  in  1  ALU error flag, qualified by alu_done.
- alu_result  in  2*ENTER_SW  ALU result.
- op_a  out  ENTER_SW  latched operand A.
- op_b  out  ENTER_SW  latched operand B.
- op_code  out  ALU_SW  latched operation.
- alu_start  out  1  one-cycle ALU launch pulse.
- result  out  2*ENTER_SW  held result.
- busy  out  1  high in EXEC.
- error  out  1  high in ERR.
- led  out  LED  active-low state indicator.

Function
REQ-008 Each key bit SHALL pass through a 2-flop synchronizer and then through a debouncer that accepts a new level only after DEB_CYCLES consecutive equal samples.
REQ-009 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition; a held key SHALL produce no further events.
REQ-010 FSM states: ENTER_A, ENTER_B, EXEC, SHOW, ERR.
REQ-011 ENTER_A: a record press SHALL latch in_number into op_a and move to ENTER_B.
REQ-012 ENTER_B: a record press SHALL latch in_number into op_b and arif into op_code. An execute press SHALL then go to ERR if op_code==all-ones, otherwise to EXEC.
REQ-013 Entry into EXEC SHALL assert alu_start for exactly one cycle, on the first EXEC cycle.
REQ-014 EXEC, alu_done=1 with alu_err=0: result <= alu_result, next state SHOW.
REQ-015 EXEC, alu_done=1 with alu_err=1: next state ERR, result unchanged.
REQ-016 EXEC: a wait counter SHALL count cycles after alu_start; reaching TIMEOUT without alu_done SHALL give ERR.
REQ-017 Key events in EXEC SHALL be ignored.
REQ-018 SHOW: a record press SHALL latch in_number into op_a and go to ENTER_B (chaining). An execute press SHALL re-launch with the same operands via EXEC.
REQ-019 ERR: any press SHALL clear result to 0 and go to ENTER_A.
REQ-020 Simultaneous record and execute events SHALL act as record only.
REQ-021 alu_done outside EXEC SHALL be ignored.
REQ-022 busy SHALL be 1 only in EXEC; error SHALL be 1 only in ERR.
REQ-023 led mapping (active-low):
- 3'b110 in ENTER_A.
- 3'b101 in ENTER_B.
- 3'b011 in EXEC and SHOW.
- 3'b000 in ERR.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst_n low SHALL asynchronously force the following, with synchronous release:
- state ENTER_A.
- op_a, op_b, op_code, result, wait counter, debouncers all 0.
- synchronizer flops and debounced key levels 1 (released).
- alu_start, busy, error 0.
- led 3'b110.
REQ-026 Reset asserted mid-EXEC SHALL abort without an alu_start or result update afterwards.

Structure
REQ-027 State encoding, LED patterns and the invalid op code SHALL live in shared package calc_pkg.
REQ-028 Debounce plus edge detection SHALL be one sub-module, key_debounce, instantiated once per key bit.

Verification
REQ-029 Entry path, with DEB_CYCLES=4:
- Stimulus: record with in_number=3, record with in_number=5 and arif=2, execute.
- Response: op_a=3, op_b=5, op_code=2, one alu_start pulse, led=3'b011.
REQ-030 Completion:
- Stimulus: in EXEC, alu_done=1 with alu_result=8'h08.
- Response: result=8'h08, state SHOW, busy=0.
REQ-031 Bounce rejection:
- Stimulus: key[1] toggling every 2 cycles for 20 cycles.
- Response: no event, op_a unchanged.
REQ-032 Timeout:
- Stimulus: TIMEOUT=10, no alu_done.
- Response: error=1 and led=3'b000 at cycle 10 after alu_start; any press then returns to ENTER_A with result=0.
REQ-033 Invalid op:
- Stimulus: arif=4'hF latched, then execute.
- Response: ERR directly, no alu_start.
REQ-034 Reset mid-operation:
- Stimulus: rst_n low during EXEC.
- Response: immediate reset values, led=3'b110.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM states, LED patterns
// and the reserved (invalid) operation code.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    // Active-low LED patterns
    localparam logic [2:0] LED_ENTER_A = 3'b110;
    localparam logic [2:0] LED_ENTER_B = 3'b101;
    localparam logic [2:0] LED_RUN     = 3'b011;
    localparam logic [2:0] LED_ERR     = 3'b000;

    // All-ones op code is reserved; sliced down to the op-code width by users
    localparam int unsigned OP_MAX_W = 32;
    localparam logic [OP_MAX_W-1:0] INVALID_OP = '1;

    function automatic logic [2:0] led_for(input state_e st);
        logic [2:0] pat;
        pat = LED_ENTER_A;
        case (st)
            ST_ENTER_A: pat = LED_ENTER_A;
            ST_ENTER_B: pat = LED_ENTER_B;
            ST_EXEC:    pat = LED_RUN;
            ST_SHOW:    pat = LED_RUN;
            ST_ERR:     pat = LED_ERR;
            default:    pat = LED_ENTER_A;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes, debounces and edge-detects one active-low push button.
// Ports: clk, rst_n (async active-low), key_raw (raw button, low = pressed),
//        press (one-cycle pulse on debounced 1->0 transition).
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation entry sequencer for a calculator ALU.
// Ports: clk, rst_n (async active-low); in_number/arif operand and op
//        switches; key[1]=record, key[0]=execute (active-low); alu_done,
//        alu_err, alu_result from the ALU; op_a, op_b, op_code, alu_start to
//        the ALU; result, busy, error, led (active-low) status. All outputs
//        are registered.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ENTER_SW   = 4,
    parameter int unsigned ALU_SW     = 4,
    parameter int unsigned RECORD     = 2,
    parameter int unsigned LED        = 3,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ENTER_SW-1:0]   in_number,
    input  logic [ALU_SW-1:0]     arif,
    input  logic [RECORD-1:0]     key,
    input  logic                  alu_done,
    input  logic                  alu_err,
    input  logic [2*ENTER_SW-1:0] alu_result,
    output logic [ENTER_SW-1:0]   op_a,
    output logic [ENTER_SW-1:0]   op_b,
    output logic [ALU_SW-1:0]     op_code,
    output logic                  alu_start,
    output logic [2*ENTER_SW-1:0] result,
    output logic                  busy,
    output logic                  error,
    output logic [LED-1:0]        led
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RES_W  = 2 * ENTER_SW;

    logic [RECORD-1:0] press;
    logic              rec_ev, exe_ev;

    for (genvar i = 0; i < int'(RECORD); i++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key[i]),
            .press   (press[i])
        );
    end

    // Record wins when both events land in the same cycle
    assign rec_ev = press[1];
    assign exe_ev = press[0] & ~press[1];

    state_e              state_q, state_d;
    logic [ENTER_SW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ALU_SW-1:0]   op_code_q, op_code_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                alu_start_q, alu_start_d;
    logic                busy_q, busy_d, error_q, error_d;
    logic [LED-1:0]      led_q, led_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        result_d  = result_q;
        wait_d    = '0;

        case (state_q)
            ST_ENTER_A: begin
                if (rec_ev) begin
                    op_a_d  = in_number;
                    state_d = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (rec_ev) begin
                    op_b_d    = in_number;
                    op_code_d = arif;
                end else if (exe_ev) begin
                    state_d = (op_code_q == INVALID_OP[ALU_SW-1:0]) ? ST_ERR : ST_EXEC;
                end
            end
            ST_EXEC: begin
                // wait_q holds the number of cycles since alu_start
                if (alu_done) begin
                    if (alu_err) begin
                        state_d = ST_ERR;
                    end else begin
                        result_d = alu_result;
                        state_d  = ST_SHOW;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_SHOW: begin
                if (rec_ev) begin
                    op_a_d  = in_number;
                    state_d = ST_ENTER_B;
                end else if (exe_ev) begin
                    state_d = ST_EXEC;
                end
            end
            ST_ERR: begin
                if (rec_ev || exe_ev) begin
                    result_d = '0;
                    state_d  = ST_ENTER_A;
                end
            end
            default: state_d = ST_ENTER_A;
        endcase

        alu_start_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
        busy_d      = (state_d == ST_EXEC);
        error_d     = (state_d == ST_ERR);
        led_d       = LED'(led_for(state_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTER_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            result_q    <= '0;
            wait_q      <= '0;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            led_q       <= LED'(LED_ENTER_A);
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            result_q    <= result_d;
            wait_q      <= wait_d;
            alu_start_q <= alu_start_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            led_q       <= led_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_code   = op_code_q;
    assign result    = result_q;
    assign alu_start = alu_start_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign led       = led_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (DEB_CYCLES=4, TIMEOUT=10).
module tb_calc_sequencer;

    localparam int unsigned EW  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned TO  = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [EW-1:0]   in_number;
    logic [AW-1:0]   arif;
    logic [1:0]      key;
    logic            alu_done;
    logic            alu_err;
    logic [2*EW-1:0] alu_result;
    logic [EW-1:0]   op_a, op_b;
    logic [AW-1:0]   op_code;
    logic            alu_start;
    logic [2*EW-1:0] result;
    logic            busy, error;
    logic [2:0]      led;

    int errors = 0;
    int checks = 0;
    int starts_seen = 0;
    int busy_seen = 0;

    always #5 clk = ~clk;

    calc_sequencer #(
        .ENTER_SW(EW), .ALU_SW(AW), .RECORD(2), .LED(3),
        .DEB_CYCLES(DEB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_number(in_number), .arif(arif), .key(key),
        .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .alu_start(alu_start),
        .result(result), .busy(busy), .error(error), .led(led)
    );

    // Advance to the next falling edge and tally start pulses / busy cycles
    task automatic tick();
        @(negedge clk);
        if (alu_start) starts_seen++;
        if (busy) busy_seen++;
    endtask

    // Hold the masked keys low long enough to debounce, then release and settle
    task automatic press_key(input logic [1:0] mask);
        key = ~mask;
        repeat (10) tick();
        key = 2'b11;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_number = '0; arif = '0; key = 2'b11;
        alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
        repeat (3) tick();
        checks++; if (op_a !== 4'h0) begin errors++; $display("FAIL reset_op_a got=%h exp=%h", op_a, 4'h0); end
        checks++; if (op_b !== 4'h0) begin errors++; $display("FAIL reset_op_b got=%h exp=%h", op_b, 4'h0); end
        checks++; if (op_code !== 4'h0) begin errors++; $display("FAIL reset_op_code got=%h exp=%h", op_code, 4'h0); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 8'h00); end
        checks++; if ({alu_start, busy, error} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=%b", {alu_start, busy, error}, 3'b000); end
        checks++; if (led !== 3'b110) begin errors++; $display("FAIL reset_led got=%b exp=%b", led, 3'b110); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_entry();
        int n;
        in_number = 4'd3;
        press_key(2'b10);
        checks++; if (op_a !== 4'd3) begin errors++; $display("FAIL entry_op_a got=%h exp=%h", op_a, 4'd3); end
        checks++; if (led !== 3'b101) begin errors++; $display("FAIL entry_led_b got=%b exp=%b", led, 3'b101); end
        in_number = 4'd5; arif = 4'd2;
        press_key(2'b10);
        checks++; if (op_b !== 4'd5) begin errors++; $display("FAIL entry_op_b got=%h exp=%h", op_b, 4'd5); end
        checks++; if (op_code !== 4'd2) begin errors++; $display("FAIL entry_op_code got=%h exp=%h", op_code, 4'd2); end
        starts_seen = 0;
        key = 2'b10;
        n = 0;
        while (!busy && n < 30) begin tick(); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL entry_busy got=%b exp=%b", busy, 1'b1); end
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL entry_start_first got=%b exp=%b", alu_start, 1'b1); end
        checks++; if (led !== 3'b011) begin errors++; $display("FAIL entry_led_exec got=%b exp=%b", led, 3'b011); end
        tick();
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL entry_start_drop got=%b exp=%b", alu_start, 1'b0); end
        checks++; if (starts_seen !== 1) begin errors++; $display("FAIL entry_start_count got=%0d exp=%0d", starts_seen, 1); end
    endtask

    task automatic test_completion();
        alu_done = 1'b1; alu_result = 8'h08;
        tick();
        alu_done = 1'b0; alu_result = '0;
        checks++; if (result !== 8'h08) begin errors++; $display("FAIL done_result got=%h exp=%h", result, 8'h08); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=%b", busy, 1'b0); end
        checks++; if ({error, led} !== 4'b0011) begin errors++; $display("FAIL done_show got=%b exp=%b", {error, led}, 4'b0011); end
        // A stray completion while in SHOW must not touch the result
        alu_done = 1'b1; alu_result = 8'h55;
        tick();
        alu_done = 1'b0; alu_result = '0;
        tick();
        checks++; if (result !== 8'h08) begin errors++; $display("FAIL stray_done_result got=%h exp=%h", result, 8'h08); end
        key = 2'b11;
        repeat (10) tick();
        checks++; if (led !== 3'b011) begin errors++; $display("FAIL held_key_show got=%b exp=%b", led, 3'b011); end
    endtask

    task automatic test_bounce();
        in_number = 4'd9;
        for (int i = 0; i < 5; i++) begin
            key = 2'b01; repeat (2) tick();
            key = 2'b11; repeat (2) tick();
        end
        repeat (10) tick();
        checks++; if (op_a !== 4'd3) begin errors++; $display("FAIL bounce_op_a got=%h exp=%h", op_a, 4'd3); end
        checks++; if (led !== 3'b011) begin errors++; $display("FAIL bounce_led got=%b exp=%b", led, 3'b011); end
    endtask

    task automatic test_chain();
        in_number = 4'd6;
        press_key(2'b10);
        checks++; if (op_a !== 4'd6) begin errors++; $display("FAIL chain_op_a got=%h exp=%h", op_a, 4'd6); end
        checks++; if (op_b !== 4'd5) begin errors++; $display("FAIL chain_op_b got=%h exp=%h", op_b, 4'd5); end
        checks++; if (led !== 3'b101) begin errors++; $display("FAIL chain_led got=%b exp=%b", led, 3'b101); end
    endtask

    task automatic test_timeout();
        int n;
        key = 2'b10;
        n = 0;
        while (!busy && n < 30) begin tick(); n++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy got=%b exp=%b", busy, 1'b1); end
        n = 0;
        while (!error && n < 40) begin tick(); n++; end
        checks++; if (n !== 10) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", n, 10); end
        checks++; if ({busy, led} !== 4'b0000) begin errors++; $display("FAIL to_err_state got=%b exp=%b", {busy, led}, 4'b0000); end
        key = 2'b11;
        repeat (10) tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_release_stays got=%b exp=%b", error, 1'b1); end
        press_key(2'b10);
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL to_clear_result got=%h exp=%h", result, 8'h00); end
        checks++; if ({error, led} !== 4'b0110) begin errors++; $display("FAIL to_back_enter_a got=%b exp=%b", {error, led}, 4'b0110); end
    endtask

    task automatic test_invalid_op();
        int n;
        in_number = 4'd1; press_key(2'b10);
        in_number = 4'd2; arif = 4'hF; press_key(2'b10);
        checks++; if (op_code !== 4'hF) begin errors++; $display("FAIL inv_op_code got=%h exp=%h", op_code, 4'hF); end
        starts_seen = 0; busy_seen = 0;
        key = 2'b10;
        n = 0;
        while (!error && n < 30) begin tick(); n++; end
        checks++; if ({error, led} !== 4'b1000) begin errors++; $display("FAIL inv_err got=%b exp=%b", {error, led}, 4'b1000); end
        checks++; if (starts_seen !== 0) begin errors++; $display("FAIL inv_no_start got=%0d exp=%0d", starts_seen, 0); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL inv_no_busy got=%0d exp=%0d", busy_seen, 0); end
        key = 2'b11;
        repeat (10) tick();
        press_key(2'b01);
        checks++; if ({error, led} !== 4'b0110) begin errors++; $display("FAIL inv_exec_clears got=%b exp=%b", {error, led}, 4'b0110); end
    endtask

    task automatic test_simultaneous();
        in_number = 4'd7; press_key(2'b10);
        in_number = 4'd4; arif = 4'd1;
        starts_seen = 0; busy_seen = 0;
        press_key(2'b11);
        checks++; if ({op_b, op_code} !== 8'h41) begin errors++; $display("FAIL simul_latch got=%h exp=%h", {op_b, op_code}, 8'h41); end
        checks++; if (led !== 3'b101) begin errors++; $display("FAIL simul_led got=%b exp=%b", led, 3'b101); end
        checks++; if (starts_seen + busy_seen !== 0) begin errors++; $display("FAIL simul_no_exec got=%0d exp=%0d", starts_seen + busy_seen, 0); end
    endtask

    task automatic test_back_to_back();
        int n;
        key = 2'b10;
        n = 0;
        while (!busy && n < 30) begin tick(); n++; end
        tick();
        alu_done = 1'b1; alu_result = 8'h21;
        tick();
        alu_done = 1'b0; alu_result = '0;
        checks++; if (result !== 8'h21) begin errors++; $display("FAIL b2b_result got=%h exp=%h", result, 8'h21); end
        key = 2'b11;
        repeat (10) tick();
        // Re-launch from SHOW with the same operands
        starts_seen = 0;
        key = 2'b10;
        n = 0;
        while (!busy && n < 30) begin tick(); n++; end
        checks++; if ({busy, alu_start} !== 2'b11) begin errors++; $display("FAIL relaunch_start got=%b exp=%b", {busy, alu_start}, 2'b11); end
        checks++; if ({op_a, op_b, op_code} !== 12'h741) begin errors++; $display("FAIL relaunch_ops got=%h exp=%h", {op_a, op_b, op_code}, 12'h741); end
    endtask

    task automatic test_reset_mid();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, error, alu_start, led} !== 6'b000110) begin errors++; $display("FAIL rmid_flags got=%b exp=%b", {busy, error, alu_start, led}, 6'b000110); end
        checks++; if ({op_a, op_b, op_code, result} !== 20'h0) begin errors++; $display("FAIL rmid_regs got=%h exp=%h", {op_a, op_b, op_code, result}, 20'h0); end
        key = 2'b11;
        alu_done = 1'b1; alu_result = 8'hAA;
        starts_seen = 0; busy_seen = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        alu_done = 1'b0; alu_result = '0;
        tick();
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rmid_no_result got=%h exp=%h", result, 8'h00); end
        checks++; if (starts_seen + busy_seen !== 0) begin errors++; $display("FAIL rmid_no_start got=%0d exp=%0d", starts_seen + busy_seen, 0); end
        checks++; if (led !== 3'b110) begin errors++; $display("FAIL rmid_led got=%b exp=%b", led, 3'b110); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_completion();
        test_bounce();
        test_chain();
        test_timeout();
        test_invalid_op();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
